cache_ctrl_nway: RTL and testbench
==================================

// Module: cache_ctrl_nway
// PURPOSE
//  Parametrised N-way set-associative write-back cache controller; successor to the single-way CACHEFSM.
//  Sits between the ufp request port and the dfp memory port and drives the tag/data SRAM control.
//  Adds tree-PLRU victim selection per set, multi-beat dfp bursts and re-lookup after a fill.
//  Tag compare is external: the controller consumes per-way valid/dirty/match vectors.
// PARAMETERS
//  WAYS   4   associativity; power of 2, >=2
//  SETS   16  sets; power of 2; SET_W = $clog2(SETS)
//  BEATS  4   dfp beats per line; >=1; BEAT_W = max(1,$clog2(BEATS))
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous reset, active-low
//  ufp_Read   in   1       read request, held until ufp_Resp
//  ufp_Write  in   1       write request, held until ufp_Resp
//  ufp_Set    in   SET_W   set index of request, stable while request held
//  way_Valid  in   WAYS    valid bits of addressed set
//  way_Dirty  in   WAYS    dirty bits of addressed set
//  way_Match  in   WAYS    tag-equal per way
//  dfp_Resp   in   1       one pulse per completed beat
//  ufp_Resp   out  1       request done, 1-cycle pulse
//  dfp_Read   out  1       line fill burst active
//  dfp_Write  out  1       victim write-back burst active
//  dfp_Beat   out  BEAT_W  current beat index of active burst
//  Sram_Op    out  3       0 NOP,1 HIT_READ,2 HIT_WRITE(set dirty),3 FILL_BEAT,4 FILL_DONE(valid,clean,tag)
//  Way_Sel    out  WAYS    one-hot way targeted by Sram_Op / dfp_Write data
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all outputs 0; beat ctr 0; all PLRU bits 0.
//  States IDLE, COMPARE, WRITE_BACK, ALLOCATE (+BYPASS with macro). Read priority if both ufp strobes.
//  IDLE: on ufp_Read|ufp_Write latch op and ufp_Set -> COMPARE next cycle.
//  COMPARE: hit = |(way_Valid & way_Match); hit way = lowest set index of that AND (multi-hit illegal).
//   Hit -> ufp_Resp=1, Sram_Op HIT_READ/HIT_WRITE, Way_Sel=hit way, PLRU touch hit way, -> IDLE.
//   Hit latency: ufp_Resp in 2nd cycle after request seen (IDLE, COMPARE).
//   Miss: victim = lowest-index invalid way, else PLRU victim; latched into victim reg.
//   Victim valid & dirty -> WRITE_BACK; else -> ALLOCATE. No ufp_Resp on miss.
//  WRITE_BACK: dfp_Write=1, Way_Sel=victim, dfp_Beat=ctr; each dfp_Resp ctr++;
//   resp on beat BEATS-1 -> ctr=0, -> ALLOCATE. dfp_Write drops the cycle after last resp.
//  ALLOCATE: dfp_Read=1; each dfp_Resp -> Sram_Op FILL_BEAT same cycle, Way_Sel=victim;
//   last beat -> Sram_Op FILL_DONE instead, PLRU touch victim, ctr=0, -> COMPARE (re-lookup, hits).
//  dfp_Resp outside WRITE_BACK/ALLOCATE ignored. ufp strobes ignored outside IDLE/COMPARE.
//  PLRU: WAYS-1 tree bits per set, SETS entries; touch sets path bits to point away from way;
//   victim follows bits (0=left). Only the latched set updated. Hit and fill in one cycle impossible.
//  BEATS=1: single resp completes a burst; dfp_Beat constant 0.
//  rst_n low mid-burst: dfp strobes and Sram_Op drop immediately (async); PLRU cleared; no partial commit.
// CONFIGURATION
//  CACHE_WRITE_NO_ALLOC_EN defined: write miss -> BYPASS: dfp_Write=1, Way_Sel=0, single beat;
//   dfp_Resp -> ufp_Resp same cycle, -> IDLE; cache and PLRU unchanged; read misses unchanged.
//  Undefined: write miss allocates (write-back/fill then re-lookup hit, HIT_WRITE).
// TESTING
//  Reset, read set 3, Valid=0001 Match=0001 -> ufp_Resp 2nd cycle, Sram_Op=1, Way_Sel=0001.
//  Read set 5, Valid=1111 Match=0000 Dirty=0000, PLRU 0 -> ALLOCATE way0, 4 FILL ops, COMPARE, hit.
//  Write miss set 2, all valid+dirty, PLRU victim way2 -> 4 dfp_Write beats (dfp_Beat 0..3), 4 fill beats, HIT_WRITE way2.
//  Hits to ways 0,1,2 in set 7 then miss -> victim way3; hit way3 then miss -> victim way0 (PLRU order).
//  rst_n low during ALLOCATE beat 2 -> dfp_Read=0 at once, state IDLE, next miss victim way0.
//  With CACHE_WRITE_NO_ALLOC_EN: write miss -> dfp_Write 1 beat, ufp_Resp with dfp_Resp, no Sram_Op.

Source files
------------

// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: N-way set-associative write-back cache controller with
// per-set tree-PLRU replacement, multi-beat dfp bursts and a re-lookup after
// every line fill. Tag compare lives outside; this block only consumes the
// per-way valid/dirty/match vectors of the addressed set.
// Optional feature macro: CACHE_WRITE_NO_ALLOC_EN (write misses bypass the
// cache with a single-beat dfp write instead of allocating).
//
// Handshakes: ufp_Read_i/ufp_Write_i are held by the requester until the
// single-cycle ufp_Resp_o pulse; dfp_Read_o/dfp_Write_o stay high for the
// whole burst and every dfp_Resp_i pulse completes exactly one beat.
module cache_ctrl_nway #(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int BEATS  = 4,
    localparam int SET_W  = $clog2(SETS),
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int WAY_W  = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ufp_Read_i,
    input  logic              ufp_Write_i,
    input  logic [SET_W-1:0]  ufp_Set_i,
    input  logic [WAYS-1:0]   way_Valid_i,
    input  logic [WAYS-1:0]   way_Dirty_i,
    input  logic [WAYS-1:0]   way_Match_i,
    input  logic              dfp_Resp_i,
    output logic              ufp_Resp_o,
    output logic              dfp_Read_o,
    output logic              dfp_Write_o,
    output logic [BEAT_W-1:0] dfp_Beat_o,
    output logic [2:0]        Sram_Op_o,
    output logic [WAYS-1:0]   Way_Sel_o
);

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_HIT_READ  = 3'd1;
    localparam logic [2:0] OP_HIT_WRITE = 3'd2;
    localparam logic [2:0] OP_FILL_BEAT = 3'd3;
    localparam logic [2:0] OP_FILL_DONE = 3'd4;
    localparam logic [WAYS-1:0] ONE_HOT0 = {{(WAYS-1){1'b0}}, 1'b1};
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WRITE_BACK, S_ALLOCATE, S_BYPASS
    } state_e;

    state_e              state_q, state_d;
    logic                op_write_q, op_write_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [BEAT_W-1:0]   ctr_q, ctr_d;
    logic [WAYS-2:0]     plru_q [SETS];

    logic [WAYS-1:0]     hit_vec;
    logic [WAY_W-1:0]    hit_idx, inv_idx, plru_vic, miss_vic;
    logic                any_inv;
    logic [WAYS-2:0]     plru_cur, plru_nxt;
    logic                touch_en;
    logic [WAY_W-1:0]    touch_way;

    // Walk the tree from the root; a 0 bit steers to the left child.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int   node;
        logic dir;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            dir = 1'b0;
            for (int n = 1; n < WAYS; n++)
                if (n == node) dir = bits[n-1];
            node = 2 * node + int'(dir);
        end
        return WAY_W'(node - WAYS);
    endfunction

    // Point every node on the path of 'way' towards the other subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] r;
        int              node;
        r    = bits;
        node = int'(way) + WAYS;
        for (int l = 0; l < WAY_W; l++) begin
            for (int n = 1; n < WAYS; n++)
                if (n == node / 2) r[n-1] = ((node % 2) == 0);
            node = node / 2;
        end
        return r;
    endfunction

    // Hit detection, lowest invalid way and PLRU candidate for the latched set.
    always_comb begin
        hit_vec = way_Valid_i & way_Match_i;
        hit_idx = '0;
        inv_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i])      hit_idx = WAY_W'(i);
            if (!way_Valid_i[i]) inv_idx = WAY_W'(i);
        end
        any_inv  = ~&way_Valid_i;
        plru_cur = plru_q[set_q];
        plru_vic = plru_victim(plru_cur);
        miss_vic = any_inv ? inv_idx : plru_vic;
        plru_nxt = plru_touch(plru_cur, touch_way);
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        set_d      = set_q;
        victim_d   = victim_q;
        ctr_d      = ctr_q;
        touch_en   = 1'b0;
        touch_way  = '0;
        ufp_Resp_o  = 1'b0;
        dfp_Read_o  = 1'b0;
        dfp_Write_o = 1'b0;
        dfp_Beat_o  = '0;
        Sram_Op_o   = OP_NOP;
        Way_Sel_o   = '0;
        case (state_q)
            S_IDLE: begin
                if (ufp_Read_i || ufp_Write_i) begin
                    op_write_d = ~ufp_Read_i;
                    set_d      = ufp_Set_i;
                    state_d    = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (|hit_vec) begin
                    ufp_Resp_o = 1'b1;
                    Sram_Op_o  = op_write_q ? OP_HIT_WRITE : OP_HIT_READ;
                    Way_Sel_o  = ONE_HOT0 << hit_idx;
                    touch_en   = 1'b1;
                    touch_way  = hit_idx;
                    state_d    = S_IDLE;
                end else begin
`ifdef CACHE_WRITE_NO_ALLOC_EN
                    if (op_write_q) begin
                        state_d = S_BYPASS;
                    end else
`endif
                    begin
                        victim_d = miss_vic;
                        state_d  = (way_Valid_i[miss_vic] && way_Dirty_i[miss_vic])
                                   ? S_WRITE_BACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITE_BACK: begin
                dfp_Write_o = 1'b1;
                dfp_Beat_o  = ctr_q;
                Way_Sel_o   = ONE_HOT0 << victim_q;
                if (dfp_Resp_i) begin
                    if (ctr_q == LAST_BEAT) begin
                        ctr_d   = '0;
                        state_d = S_ALLOCATE;
                    end else begin
                        ctr_d = ctr_q + BEAT_W'(1);
                    end
                end
            end
            S_ALLOCATE: begin
                dfp_Read_o = 1'b1;
                dfp_Beat_o = ctr_q;
                Way_Sel_o  = ONE_HOT0 << victim_q;
                if (dfp_Resp_i) begin
                    if (ctr_q == LAST_BEAT) begin
                        Sram_Op_o = OP_FILL_DONE;
                        touch_en  = 1'b1;
                        touch_way = victim_q;
                        ctr_d     = '0;
                        state_d   = S_COMPARE;
                    end else begin
                        Sram_Op_o = OP_FILL_BEAT;
                        ctr_d     = ctr_q + BEAT_W'(1);
                    end
                end
            end
`ifdef CACHE_WRITE_NO_ALLOC_EN
            S_BYPASS: begin
                dfp_Write_o = 1'b1;
                if (dfp_Resp_i) begin
                    ufp_Resp_o = 1'b1;
                    state_d    = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_write_q <= 1'b0;
            set_q      <= '0;
            victim_q   <= '0;
            ctr_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            set_q      <= set_d;
            victim_q   <= victim_d;
            ctr_q      <= ctr_d;
        end
    end

    // PLRU tree bits; only the latched set is ever updated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SETS; i++) plru_q[i] <= '0;
        end else if (touch_en) begin
            plru_q[set_q] <= plru_nxt;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb_cache_ctrl_nway: bench for cache_ctrl_nway. The bench plays the tag/valid
// SRAM and the memory side, and predicts every transaction from a behavioural
// cache model (valid/dirty/tag arrays plus per-set PLRU bits).
module tb_cache_ctrl_nway;

  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int BEATS  = 4;
  localparam int SET_W  = $clog2(SETS);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LEVELS = $clog2(WAYS);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ufp_Read = 1'b0;
  logic              ufp_Write = 1'b0;
  logic [SET_W-1:0]  ufp_Set = '0;
  logic [WAYS-1:0]   way_Valid = '0;
  logic [WAYS-1:0]   way_Dirty = '0;
  logic [WAYS-1:0]   way_Match = '0;
  logic              dfp_Resp = 1'b0;
  logic              ufp_Resp;
  logic              dfp_Read;
  logic              dfp_Write;
  logic [BEAT_W-1:0] dfp_Beat;
  logic [2:0]        Sram_Op;
  logic [WAYS-1:0]   Way_Sel;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit mv [SETS][WAYS];
  bit md [SETS][WAYS];
  int mt [SETS][WAYS];
  bit mp [SETS][WAYS];   // tree nodes 1..WAYS-1, 1 = victim lies to the right

  cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ufp_Read_i(ufp_Read), .ufp_Write_i(ufp_Write), .ufp_Set_i(ufp_Set),
    .way_Valid_i(way_Valid), .way_Dirty_i(way_Dirty), .way_Match_i(way_Match),
    .dfp_Resp_i(dfp_Resp),
    .ufp_Resp_o(ufp_Resp), .dfp_Read_o(dfp_Read), .dfp_Write_o(dfp_Write),
    .dfp_Beat_o(dfp_Beat), .Sram_Op_o(Sram_Op), .Way_Sel_o(Way_Sel)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // model: victim chosen by walking the tree bits from the root
  function automatic int model_victim(input int s);
    int node;
    node = 1;
    for (int l = 0; l < LEVELS; l++) node = 2 * node + int'(mp[s][node]);
    return node - WAYS;
  endfunction

  // model: each level of the way's path points at the sibling subtree
  function automatic void model_touch(input int s, input int w);
    int node, dir;
    for (int l = 0; l < LEVELS; l++) begin
      node = (1 << l) + (w >> (LEVELS - l));
      dir  = (w >> (LEVELS - 1 - l)) & 1;
      mp[s][node] = (dir == 0);
    end
  endfunction

  function automatic void model_clear_plru();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) mp[s][w] = 1'b0;
  endfunction

  task automatic drive_ways(input int s, input int tag);
    for (int w = 0; w < WAYS; w++) begin
      way_Valid[w] = mv[s][w];
      way_Dirty[w] = md[s][w];
      way_Match[w] = (mt[s][w] == tag);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_resp"},  int'(ufp_Resp), 0);
    check_eq({tag, "_rd"},    int'(dfp_Read), 0);
    check_eq({tag, "_wr"},    int'(dfp_Write), 0);
    check_eq({tag, "_beat"},  int'(dfp_Beat), 0);
    check_eq({tag, "_op"},    int'(Sram_Op), 0);
    check_eq({tag, "_sel"},   int'(Way_Sel), 0);
  endtask

  // one ufp request from IDLE to completion; abort_at >= 0 pulls reset
  // at the start of that fill beat
  task automatic do_req(input bit wr, input int s, input int tag, input int abort_at);
    int hw, v, n;
    bit wb;
    @(negedge clk);
    ufp_Read  = !wr;
    ufp_Write = wr;
    ufp_Set   = SET_W'(s);
    drive_ways(s, tag);
    #1 check_eq("idle_resp", int'(ufp_Resp), 0);
    hw = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (mv[s][w] && mt[s][w] == tag) hw = w;
    @(negedge clk); #1;
    if (hw >= 0) begin
      check_eq("hit_resp", int'(ufp_Resp), 1);
      check_eq("hit_op",   int'(Sram_Op), wr ? 2 : 1);
      check_eq("hit_sel",  int'(Way_Sel), 1 << hw);
      model_touch(s, hw);
      if (wr) md[s][hw] = 1'b1;
      ufp_Read = 1'b0; ufp_Write = 1'b0;
      return;
    end
    check_eq("miss_resp", int'(ufp_Resp), 0);
    check_eq("miss_op",   int'(Sram_Op), 0);
`ifdef CACHE_WRITE_NO_ALLOC_EN
    if (wr) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i <= n; i++) begin
        @(negedge clk); dfp_Resp = (i == n); #1;
        check_eq("byp_wr",   int'(dfp_Write), 1);
        check_eq("byp_sel",  int'(Way_Sel), 0);
        check_eq("byp_op",   int'(Sram_Op), 0);
        check_eq("byp_resp", int'(ufp_Resp), (i == n) ? 1 : 0);
      end
      @(negedge clk); dfp_Resp = 1'b0; ufp_Read = 1'b0; ufp_Write = 1'b0;
      #1 check_eq("byp_done", int'(dfp_Write), 0);
      return;
    end
`endif
    v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
    if (v < 0) v = model_victim(s);
    wb = mv[s][v] && md[s][v];
    if (wb) begin
      for (int b = 0; b < BEATS; b++) begin
        n = $urandom_range(0, 2);
        for (int i = 0; i <= n; i++) begin
          @(negedge clk); dfp_Resp = (i == n); #1;
          check_eq("wb_wr",   int'(dfp_Write), 1);
          check_eq("wb_rd",   int'(dfp_Read), 0);
          check_eq("wb_beat", int'(dfp_Beat), b);
          check_eq("wb_sel",  int'(Way_Sel), 1 << v);
          check_eq("wb_op",   int'(Sram_Op), 0);
        end
      end
    end
    for (int b = 0; b < BEATS; b++) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i <= n; i++) begin
        @(negedge clk);
        if (b == abort_at) begin
          dfp_Resp = 1'b0;
          #1 check_eq("abort_pre_rd", int'(dfp_Read), 1);
          check_eq("abort_pre_beat", int'(dfp_Beat), b);
          #1 rst_n = 1'b0;
          #1 check_quiet("abort");
          model_clear_plru();
          @(negedge clk);
          rst_n = 1'b1; ufp_Read = 1'b0; ufp_Write = 1'b0;
          #1 check_quiet("abort_idle");
          return;
        end
        dfp_Resp = (i == n); #1;
        check_eq("fill_rd",   int'(dfp_Read), 1);
        check_eq("fill_wr",   int'(dfp_Write), 0);
        check_eq("fill_beat", int'(dfp_Beat), b);
        check_eq("fill_sel",  int'(Way_Sel), 1 << v);
        check_eq("fill_op",   int'(Sram_Op), (i != n) ? 0 : ((b == BEATS - 1) ? 4 : 3));
      end
    end
    mv[s][v] = 1'b1; md[s][v] = 1'b0; mt[s][v] = tag;
    model_touch(s, v);
    @(negedge clk);
    dfp_Resp = 1'b0;
    drive_ways(s, tag);
    #1;
    check_eq("relook_resp", int'(ufp_Resp), 1);
    check_eq("relook_op",   int'(Sram_Op), wr ? 2 : 1);
    check_eq("relook_sel",  int'(Way_Sel), 1 << v);
    check_eq("relook_rd",   int'(dfp_Read), 0);
    model_touch(s, v);
    if (wr) md[s][v] = 1'b1;
    ufp_Read = 1'b0; ufp_Write = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 1'b0; md[s][w] = 1'b0; mt[s][w] = 1000 + w;
      end
    model_clear_plru();
    // set 3: only way0 valid holding tag 5
    mv[3][0] = 1'b1; mt[3][0] = 5;
    // set 5: all valid and clean
    for (int w = 0; w < WAYS; w++) begin mv[5][w] = 1'b1; mt[5][w] = 10 + w; end
    // set 2: all valid and dirty
    for (int w = 0; w < WAYS; w++) begin mv[2][w] = 1'b1; md[2][w] = 1'b1; mt[2][w] = 30 + w; end
    // set 7: ways 0..2 valid, way3 invalid
    for (int w = 0; w < 3; w++) begin mv[7][w] = 1'b1; mt[7][w] = 50 + w; end

    #2 check_quiet("reset");
    @(negedge clk); rst_n = 1'b1;
    #1 check_quiet("post_reset");

    // stray dfp_Resp while idle has no effect
    @(negedge clk); dfp_Resp = 1'b1;
    #1 check_quiet("stray_resp");
    @(negedge clk); dfp_Resp = 1'b0;
    #1 check_quiet("stray_after");

    do_req(1'b0, 3, 5, -1);     // read hit way0
    do_req(1'b0, 5, 20, -1);    // read miss, clean victim way0
    do_req(1'b0, 2, 31, -1);    // hit way1 steers PLRU to way2
    do_req(1'b1, 2, 40, -1);    // write miss, dirty victim way2
    do_req(1'b0, 7, 50, -1);
    do_req(1'b0, 7, 51, -1);
    do_req(1'b0, 7, 52, -1);
    do_req(1'b0, 7, 60, -1);    // miss fills invalid way3
    do_req(1'b0, 7, 60, -1);    // hit way3
    do_req(1'b0, 7, 61, -1);    // miss, PLRU victim way0
    do_req(1'b0, 5, 21, 2);     // reset during fill beat 2
    do_req(1'b0, 5, 22, -1);    // PLRU cleared, victim way0

    for (int k = 0; k < 60; k++)
      do_req(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 7), -1);

    @(negedge clk);
    #1 check_quiet("final_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
